// File: rtl/obi_interconnect_pkg.sv
// Shared types for the sys_bus interconnect blocks.
package obi_interconnect_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } obi_arb_state_e;

endpackage

// File: rtl/obi_id_fifo.sv
// Small ID FIFO recording which master owns each accepted transaction.
module obi_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (AW == 0) ? 1 : AW;

    // Pointers carry one extra MSB so full and empty stay distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] mem_q [2**IW];

    generate
        if (AW == 0) begin : g_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_multi
            assign wr_idx = wr_ptr_q[IW-1:0];
            assign rd_idx = rd_ptr_q[IW-1:0];
        end
    endgenerate

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/obi_slave_rr_arbiter.sv
// Per-slave OBI round-robin arbiter with a response-routing ID queue.
// state | meaning:  ARB = pick a winner each cycle  |  HOLD = request pending, selection frozen
module obi_slave_rr_arbiter
    import obi_interconnect_pkg::*;
#(
    parameter int MASTERS         = 3,
    parameter int MASTER_BITS     = (MASTERS == 1) ? 1 : $clog2(MASTERS),
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [MASTERS-1:0]            master_req_i,
    input  logic [MASTERS-1:0][31:0]      master_addr_i,
    input  logic [31:0]                   slave_addr_mask_i,
    input  logic [31:0]                   slave_addr_base_i,
    output logic [MASTERS-1:0]            master_gnt_o,
    output logic [MASTERS-1:0]            master_rvalid_o,
    output logic                          slave_req_o,
    input  logic                          slave_gnt_i,
    input  logic                          slave_rvalid_i,
    output logic [MASTER_BITS-1:0]        req_sel_int_o,
    output logic [MASTER_BITS-1:0]        rsp_sel_int_o,
    output logic                          busy_o,
    output logic                          proto_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    // Rotate the doubled request vector so bit 0 is rr_ptr, then take the first set bit.
    function automatic logic [MASTER_BITS-1:0] rr_pick(input logic [MASTERS-1:0]     elig,
                                                       input logic [MASTER_BITS-1:0] ptr);
        logic [2*MASTERS-1:0]   shifted;
        logic [MASTER_BITS-1:0] pick;
        logic                   found;
        int                     idx;
        shifted = {elig, elig} >> ptr;
        pick    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < MASTERS; i++) begin
            if (shifted[i] && !found) begin
                found = 1'b1;
                idx   = int'(ptr) + i;
                if (idx >= MASTERS) idx = idx - MASTERS;
                pick  = MASTER_BITS'(idx);
            end
        end
        return pick;
    endfunction

    obi_arb_state_e         state_q;
    logic [MASTER_BITS-1:0] rr_ptr_q;
    logic [MASTER_BITS-1:0] lock_id_q;
    logic [MASTER_BITS-1:0] winner;
    logic [MASTER_BITS-1:0] sel;
    logic [MASTER_BITS-1:0] head;
    logic [MASTERS-1:0]     eligible;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   can_issue;
    logic                   req_int;
    logic                   handshake;
    logic                   pop;
    logic                   proto_err_q;

    always_comb begin
        eligible = '0;
        for (int m = 0; m < MASTERS; m++) begin
            eligible[m] = master_req_i[m] &
                          ((master_addr_i[m] & slave_addr_mask_i) == slave_addr_base_i);
        end
    end

    assign can_issue = !fifo_full;
    assign winner    = rr_pick(eligible, rr_ptr_q);
    assign sel       = (state_q == HOLD) ? lock_id_q : winner;
    assign req_int   = (state_q == HOLD) | (can_issue & (|eligible));

    // Combinational paths from master_req_i are forced low while reset is asserted.
    assign slave_req_o   = rst_ni & req_int;
    assign req_sel_int_o = rst_ni ? sel : '0;
    assign handshake     = slave_req_o & slave_gnt_i;
    assign pop           = slave_rvalid_i & !fifo_empty;
    assign rsp_sel_int_o = fifo_empty ? '0 : head;
    assign busy_o        = (count != '0) | (state_q == HOLD);
    assign proto_err_o   = proto_err_q;

    always_comb begin
        master_gnt_o    = '0;
        master_rvalid_o = '0;
        for (int m = 0; m < MASTERS; m++) begin
            master_gnt_o[m]    = handshake && (sel == MASTER_BITS'(m));
            master_rvalid_o[m] = pop && (head == MASTER_BITS'(m));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (req_int && !slave_gnt_i) begin
                        state_q   <= HOLD;
                        lock_id_q <= winner;
                    end
                end
                HOLD: begin
                    if (slave_gnt_i) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
            if (handshake) begin
                rr_ptr_q <= (sel == MASTER_BITS'(MASTERS-1)) ? '0 : sel + MASTER_BITS'(1);
            end
            if (slave_rvalid_i && fifo_empty) proto_err_q <= 1'b1;
        end
    end

    obi_id_fifo #(
        .WIDTH (MASTER_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .pop_i   (pop),
        .data_i  (sel),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (count)
    );

endmodule

// File: tb/tb_obi_slave_rr_arbiter.sv
// Self-checking bench for obi_slave_rr_arbiter: vector table, directed corners, random vs. model.
module tb_obi_slave_rr_arbiter;

    localparam int M    = 3;
    localparam int MB   = 2;
    localparam int MAXO = 2;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [M-1:0]       master_req_i;
    logic [M-1:0][31:0] master_addr_i;
    logic [31:0]        slave_addr_mask_i;
    logic [31:0]        slave_addr_base_i;
    logic [M-1:0]       master_gnt_o;
    logic [M-1:0]       master_rvalid_o;
    logic               slave_req_o;
    logic               slave_gnt_i;
    logic               slave_rvalid_i;
    logic [MB-1:0]      req_sel_int_o;
    logic [MB-1:0]      rsp_sel_int_o;
    logic               busy_o;
    logic               proto_err_o;

    obi_slave_rr_arbiter #(
        .MASTERS         (M),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .master_req_i      (master_req_i),
        .master_addr_i     (master_addr_i),
        .slave_addr_mask_i (slave_addr_mask_i),
        .slave_addr_base_i (slave_addr_base_i),
        .master_gnt_o      (master_gnt_o),
        .master_rvalid_o   (master_rvalid_o),
        .slave_req_o       (slave_req_o),
        .slave_gnt_i       (slave_gnt_i),
        .slave_rvalid_i    (slave_rvalid_i),
        .req_sel_int_o     (req_sel_int_o),
        .rsp_sel_int_o     (rsp_sel_int_o),
        .busy_o            (busy_o),
        .proto_err_o       (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of owning masters, next-priority pointer, pending-request lock.
    int q_ids[$];
    int m_rr;
    bit m_hold;
    int m_lock;
    bit m_err;

    typedef struct {
        logic [2:0] req;
        logic       gnt;
        logic       rvalid;
        logic       exp_req;
        logic [1:0] exp_sel;
        logic [2:0] exp_gnt;
        logic [2:0] exp_rvalid;
        logic [1:0] exp_rsp;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit elig(input int m);
        return master_req_i[m] && ((master_addr_i[m] & slave_addr_mask_i) == slave_addr_base_i);
    endfunction

    function automatic int model_sel();
        if (m_hold) return m_lock;
        for (int k = 0; k < M; k++) begin
            if (elig((m_rr + k) % M)) return (m_rr + k) % M;
        end
        return -1;
    endfunction

    function automatic bit model_req();
        return m_hold || (q_ids.size() < MAXO && model_sel() >= 0);
    endfunction

    task automatic model_reset();
        q_ids.delete();
        m_rr   = 0;
        m_hold = 0;
        m_lock = 0;
        m_err  = 0;
    endtask

    task automatic drive(input logic [2:0] r, input logic g, input logic v);
        master_req_i   = r;
        slave_gnt_i    = g;
        slave_rvalid_i = v;
        #2;
    endtask

    // Called a little after the falling edge with inputs already applied; ends at the next falling edge.
    task automatic step(input string tag);
        int s;
        bit r;
        int eg;
        int ev;
        #2;
        s  = model_sel();
        r  = model_req();
        eg = (r && slave_gnt_i) ? (1 << s) : 0;
        ev = (slave_rvalid_i && q_ids.size() > 0) ? (1 << q_ids[0]) : 0;
        chk({tag, " req"}, int'(slave_req_o), int'(r));
        if (r) chk({tag, " sel"}, int'(req_sel_int_o), s);
        chk({tag, " gnt"}, int'(master_gnt_o), eg);
        chk({tag, " rvalid"}, int'(master_rvalid_o), ev);
        chk({tag, " rsp_sel"}, int'(rsp_sel_int_o), (q_ids.size() > 0) ? q_ids[0] : 0);
        chk({tag, " busy"}, int'(busy_o), int'(q_ids.size() != 0 || m_hold));
        chk({tag, " err"}, int'(proto_err_o), int'(m_err));
        @(posedge clk_i);
        if (slave_rvalid_i) begin
            if (q_ids.size() > 0) void'(q_ids.pop_front());
            else m_err = 1;
        end
        if (r && slave_gnt_i) begin
            q_ids.push_back(s);
            m_rr   = (s + 1) % M;
            m_hold = 0;
        end else if (r && !m_hold) begin
            m_hold = 1;
            m_lock = s;
        end
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'b111, 1'b1, 1'b0, 1'b1, 2'd0, 3'b001, 3'b000, 2'd0, 1'b0};
        tbl[1] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd1, 3'b010, 3'b001, 2'd0, 1'b1};
        tbl[2] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 3'b100, 3'b010, 2'd1, 1'b1};
        tbl[3] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd0, 3'b001, 3'b100, 2'd2, 1'b1};
        tbl[4] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd1, 3'b010, 3'b001, 2'd0, 1'b1};
        tbl[5] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 3'b100, 3'b010, 2'd1, 1'b1};
        tbl[6] = '{3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 3'b100, 2'd2, 1'b1};
        tbl[7] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 2'd0, 1'b0};

        // Reset with every input active
        model_reset();
        rst_ni            = 1'b0;
        slave_addr_mask_i = 32'hF000_0000;
        slave_addr_base_i = 32'h1000_0000;
        for (int m = 0; m < M; m++) master_addr_i[m] = 32'h1000_0000 + 32'(4 * m);
        master_req_i   = 3'b111;
        slave_gnt_i    = 1'b1;
        slave_rvalid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2;
        chk("rst req", int'(slave_req_o), 0);
        chk("rst gnt", int'(master_gnt_o), 0);
        chk("rst rvalid", int'(master_rvalid_o), 0);
        chk("rst req_sel", int'(req_sel_int_o), 0);
        chk("rst rsp_sel", int'(rsp_sel_int_o), 0);
        chk("rst busy", int'(busy_o), 0);
        chk("rst err", int'(proto_err_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fairness table: continuous requests, rvalid one cycle after each grant
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].req, tbl[i].gnt, tbl[i].rvalid);
            chk($sformatf("tbl%0d req", i), int'(slave_req_o), int'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d sel", i), int'(req_sel_int_o), int'(tbl[i].exp_sel));
            chk($sformatf("tbl%0d gnt", i), int'(master_gnt_o), int'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d rvalid", i), int'(master_rvalid_o), int'(tbl[i].exp_rvalid));
            chk($sformatf("tbl%0d rsp_sel", i), int'(rsp_sel_int_o), int'(tbl[i].exp_rsp));
            chk($sformatf("tbl%0d busy", i), int'(busy_o), int'(tbl[i].exp_busy));
            step($sformatf("tbl%0d", i));
        end

        // Hold: m1 waits three cycles, m0 joins in cycle 2 but must not steal the slot
        drive(3'b010, 1'b0, 1'b0);
        chk("hold c1 sel", int'(req_sel_int_o), 1);
        step("hold c1");
        drive(3'b011, 1'b0, 1'b0);
        chk("hold c2 sel", int'(req_sel_int_o), 1);
        chk("hold c2 busy", int'(busy_o), 1);
        step("hold c2");
        drive(3'b011, 1'b0, 1'b0);
        chk("hold c3 sel", int'(req_sel_int_o), 1);
        chk("hold c3 req", int'(slave_req_o), 1);
        step("hold c3");
        drive(3'b011, 1'b1, 1'b0);
        chk("hold gnt m1", int'(master_gnt_o), 3'b010);
        step("hold c4");
        drive(3'b001, 1'b1, 1'b1);
        chk("hold gnt m0", int'(master_gnt_o), 3'b001);
        chk("hold rvalid m1", int'(master_rvalid_o), 3'b010);
        step("hold c5");
        drive(3'b000, 1'b0, 1'b1);
        chk("hold rvalid m0", int'(master_rvalid_o), 3'b001);
        step("hold c6");

        // Outstanding limit: two accepted, third stalls even while a response pops
        drive(3'b100, 1'b1, 1'b0);
        chk("out gnt m2", int'(master_gnt_o), 3'b100);
        step("out c1");
        drive(3'b001, 1'b1, 1'b0);
        chk("out gnt m0", int'(master_gnt_o), 3'b001);
        step("out c2");
        drive(3'b111, 1'b1, 1'b0);
        chk("out full stall", int'(slave_req_o), 0);
        chk("out full busy", int'(busy_o), 1);
        step("out c3");
        drive(3'b111, 1'b1, 1'b1);
        chk("out full pop stall", int'(slave_req_o), 0);
        chk("out rvalid m2", int'(master_rvalid_o), 3'b100);
        chk("out rsp m2", int'(rsp_sel_int_o), 2);
        step("out c4");
        drive(3'b000, 1'b0, 1'b1);
        chk("out rvalid m0", int'(master_rvalid_o), 3'b001);
        chk("out rsp m0", int'(rsp_sel_int_o), 0);
        step("out c5");

        // Address decode: m0 outside the window never wins
        master_addr_i[0] = 32'h2000_0000;
        master_addr_i[1] = 32'h1000_0004;
        for (int i = 0; i < 4; i++) begin
            drive(3'b011, 1'b1, (i > 0));
            chk($sformatf("dec%0d gnt", i), int'(master_gnt_o), 3'b010);
            step($sformatf("dec%0d", i));
        end
        drive(3'b000, 1'b0, 1'b1);
        step("dec drain");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < M; m++) begin
                master_req_i[m] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) master_addr_i[m] = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
                else master_addr_i[m] = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
            end
            slave_gnt_i    = 1'($urandom_range(0, 1));
            slave_rvalid_i = (q_ids.size() > 0) && ($urandom_range(0, 2) != 0);
            step("rnd");
        end

        // Drain before the protocol-error checks, bounded
        for (int i = 0; i < 10 && (q_ids.size() > 0 || m_hold); i++) begin
            master_req_i   = 3'b000;
            slave_gnt_i    = 1'b1;
            slave_rvalid_i = (q_ids.size() > 0);
            step("drain");
        end
        drive(3'b000, 1'b0, 1'b0);
        chk("drain busy", int'(busy_o), 0);
        step("drain idle");

        // Stray rvalid with empty queue
        drive(3'b000, 1'b0, 1'b1);
        chk("err no rvalid", int'(master_rvalid_o), 0);
        chk("err before", int'(proto_err_o), 0);
        step("err c1");
        drive(3'b000, 1'b0, 1'b0);
        chk("err set", int'(proto_err_o), 1);
        step("err c2");
        step("err c3");
        chk("err sticky", int'(proto_err_o), 1);

        // Reset mid-transaction, then a late response
        drive(3'b001, 1'b1, 1'b0);
        step("late c1");
        rst_ni = 1'b0;
        model_reset();
        drive(3'b000, 1'b0, 1'b0);
        chk("late rst err", int'(proto_err_o), 0);
        chk("late rst busy", int'(busy_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(3'b000, 1'b0, 1'b1);
        chk("late no rvalid", int'(master_rvalid_o), 0);
        step("late c2");
        drive(3'b000, 1'b0, 1'b0);
        chk("late err set", int'(proto_err_o), 1);
        step("late c3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
